// File: rtl/umips_fetch_pkg.sv
// umips fetch unit: shared types and field constants.
// Loaded first so its macros are visible to every later file.
`ifndef UMIPS_FETCH_VH
`define UMIPS_FETCH_VH
`define FETCH_PC_INC 32'd4
`define INSTR_NOP 32'h0000_0000
`define OPCODE_MSB 31
`define OPCODE_LSB 26
`define FUNCT_MSB 5
`define FUNCT_LSB 0
`endif

package umips_fetch_pkg;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/umips_fetch_fifo.sv
// umips fetch unit: prefetch FIFO holding instruction word and PC tag.
// Flush wins over push and pop in the same cycle.
module umips_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/umips_fetch_unit.sv
// umips fetch unit: PC, imem request/credit, redirect discard, prefetch.
// Optional UMIPS_FETCH_PERF_EN adds saturating performance counters.
module umips_fetch_unit
    import umips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  ifunct
`ifdef UMIPS_FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_empty_cycles,
    output logic [31:0] perf_redirects
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 2;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   target_pc;
    logic [CW-1:0] live;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] inflight;
    logic          credit;
    logic          fifo_full;
    logic          fifo_empty;
    logic          hs;
    logic          rv_drop;
    logic          rv_live;
    logic          rv_take;
    logic          unused_ok;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    assign target_pc = {redirect_pc[31:2], 2'b00};
    assign unused_ok = ^redirect_pc[1:0];

    assign inflight = SW'(live) + SW'(discard) + SW'(fifo_count);
    assign credit   = (inflight < SW'(FIFO_DEPTH)) & ~fifo_full;
    assign imem_req  = rst & ~redirect & credit;
    assign imem_addr = fetch_pc;
    assign hs        = imem_req & imem_gnt;

    assign rv_drop = imem_rvalid & (discard != '0);
    assign rv_live = imem_rvalid & (discard == '0) & (live != '0);
    assign rv_take = rv_drop | rv_live;

    assign push_entry = '{word: imem_rdata, pc: resp_pc};

    umips_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rv_live & ~redirect),
        .pop   (instr_valid & ~stall),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign instr_valid = rst & ~fifo_empty;
    assign instr    = instr_valid ? head_entry.word : `INSTR_NOP;
    assign instr_pc = instr_valid ? head_entry.pc : 32'h0;
    assign opcode   = instr[`OPCODE_MSB:`OPCODE_LSB];
    assign ifunct   = instr[`FUNCT_MSB:`FUNCT_LSB];

    // Fetch/response PCs and in-flight accounting; redirect dominates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            live     <= '0;
            discard  <= '0;
        end else if (redirect) begin
            fetch_pc <= target_pc;
            resp_pc  <= target_pc;
            live     <= '0;
            discard  <= discard + live - CW'(rv_take);
        end else begin
            if (hs)
                fetch_pc <= fetch_pc + `FETCH_PC_INC;
            if (rv_live)
                resp_pc <= resp_pc + `FETCH_PC_INC;
            live    <= live + CW'(hs) - CW'(rv_live);
            discard <= discard - CW'(rv_drop);
        end
    end

    // A response with nothing outstanding breaks the memory protocol.
    always_ff @(posedge clk) begin
        if (rst)
            assert (!(imem_rvalid && live == '0 && discard == '0));
    end

`ifdef UMIPS_FETCH_PERF_EN
    // Saturating event counters, untouched by redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
            perf_empty_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (stall && instr_valid && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (!instr_valid && perf_empty_cycles != '1)
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
            if (redirect && perf_redirects != '1)
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule
